// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port: address channel moves on valid&&ready, data returns in request order
// with no backpressure on the return path.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int PIXEL_W = 12
);
  logic [ADDR_W-1:0]  fb_addr;
  logic               fb_addr_valid;
  logic               fb_addr_ready;
  logic [PIXEL_W-1:0] fb_data;
  logic               fb_data_valid;

  modport master (
    output fb_addr, fb_addr_valid,
    input  fb_addr_ready, fb_data, fb_data_valid
  );

  modport slave (
    input  fb_addr, fb_addr_valid,
    output fb_addr_ready, fb_data, fb_data_valid
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Row prefetch into a ping-pong line buffer, 2**SCALE_SHIFT replication, 2-cycle pixel/sync latency;
// fetch stalls on fb_addr_ready, data beats cannot be stalled. VGA_TEST_PATTERN_EN adds colour bars.
module vga_pixel_fetch #(
  parameter int FB_W        = 256,
  parameter int FB_H        = 192,
  parameter int SCALE_SHIFT = 2,
  parameter int PIXEL_W     = 12,
  parameter int ADDR_W      = 16
) (
  input  logic        clk_75MHz,
  input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern_i,
`endif
  input  logic        hsync_n_i,
  input  logic        vsync_n_i,
  input  logic        in_display_i,
  input  logic [9:0]  hcount_i,
  input  logic [9:0]  vcount_i,
  vga_pixel_fetch_if.master fb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync_n,
  output logic        vga_vsync_n,
  output logic        underrun
);

  localparam int COL_W    = $clog2(FB_W);
  localparam int V_ACTIVE = FB_H << SCALE_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_hs_prev, r_de_prev;
  logic [ADDR_W-1:0]   r_addr;
  logic [COL_W-1:0]    r_req_cnt, r_wr_col;
  logic                r_disp_bank, r_pending, r_underrun;
  logic [PIXEL_W-1:0]  r_lb [2*FB_W];
  logic [PIXEL_W-1:0]  r_rd_dat;
  logic                r_hs_d1, r_vs_d1, r_de_d1;

  logic [9:0]          w_next, w_row;
  logic [ADDR_W-1:0]   w_base;
  logic                w_trigger, w_start, w_busy, w_swap, w_rd_bank;
  logic                w_addr_acc, w_beat, w_last_req, w_last_beat;
  logic [COL_W-1:0]    w_rd_col;
  logic [11:0]         w_pix;
  logic                w_unused;

  assign w_next      = (vcount_i == 10'd805) ? 10'd0 : vcount_i + 10'd1;
  assign w_row       = w_next >> SCALE_SHIFT;
  assign w_base      = ADDR_W'(w_row) * ADDR_W'(FB_W);
  assign w_trigger   = r_hs_prev & ~hsync_n_i;
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = w_trigger && !w_busy && (int'(w_next) < V_ACTIVE)
                       && (w_next[SCALE_SHIFT-1:0] == '0);
  assign w_addr_acc  = fb.fb_addr_valid && fb.fb_addr_ready;
  assign w_beat      = fb.fb_data_valid && w_busy;
  assign w_last_req  = w_addr_acc && (r_req_cnt == COL_W'(FB_W - 1));
  assign w_last_beat = w_beat && (r_wr_col == COL_W'(FB_W - 1));
  assign w_swap      = in_display_i && !r_de_prev;
  assign w_unused    = ^hcount_i[SCALE_SHIFT-1:0];

  assign fb.fb_addr       = r_addr;
  assign fb.fb_addr_valid = (r_state == S_REQ);
  assign underrun         = r_underrun;

  always_ff @(posedge clk_75MHz) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A zero-latency memory may return the last beat in the same cycle as the last address.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)     w_state_nxt = S_REQ;
      S_REQ:   if (w_last_req)  w_state_nxt = w_last_beat ? S_IDLE : S_WAIT;
      S_WAIT:  if (w_last_beat) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_75MHz) begin
    if (reset) begin
      r_hs_prev   <= 1'b1;
      r_de_prev   <= 1'b0;
      r_addr      <= '0;
      r_req_cnt   <= '0;
      r_wr_col    <= '0;
      r_disp_bank <= 1'b0;
      r_pending   <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_hs_prev <= hsync_n_i;
      r_de_prev <= in_display_i;
      if (w_start) begin
        r_addr    <= w_base;
        r_req_cnt <= '0;
        r_wr_col  <= '0;
      end else begin
        if (w_addr_acc) begin
          r_addr    <= r_addr + 1'b1;
          r_req_cnt <= r_req_cnt + 1'b1;
        end
        if (w_beat) r_wr_col <= r_wr_col + 1'b1;
      end
      // A late fetch keeps running and is picked up at the next line start.
      if (w_swap && r_pending) begin
        r_disp_bank <= ~r_disp_bank;
        r_pending   <= 1'b0;
      end else begin
        if (w_swap && w_busy) r_underrun <= 1'b1;
        if (w_last_beat)      r_pending  <= 1'b1;
      end
    end
  end

  // The first pixel of a line is read in the swap cycle, so it must see the new bank.
  assign w_rd_bank = (w_swap && r_pending) ? ~r_disp_bank : r_disp_bank;
  assign w_rd_col  = hcount_i[SCALE_SHIFT +: COL_W];

  always_ff @(posedge clk_75MHz) begin
    if (w_beat && !reset) r_lb[{~r_disp_bank, r_wr_col}] <= fb.fb_data;
    r_rd_dat <= r_lb[{w_rd_bank, w_rd_col}];
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] r_bar;
  logic       r_tp_d1;

  always_ff @(posedge clk_75MHz) begin
    if (reset) begin
      r_bar   <= '0;
      r_tp_d1 <= 1'b0;
    end else begin
      r_bar   <= hcount_i[9:7];
      r_tp_d1 <= test_pattern_i;
    end
  end

  assign w_pix = r_tp_d1 ? {3{r_bar, r_bar[0]}} : r_rd_dat;
`else
  assign w_pix = r_rd_dat;
`endif

  always_ff @(posedge clk_75MHz) begin
    if (reset) begin
      r_hs_d1     <= 1'b1;
      r_vs_d1     <= 1'b1;
      r_de_d1     <= 1'b0;
      vga_hsync_n <= 1'b1;
      vga_vsync_n <= 1'b1;
      {vga_r, vga_g, vga_b} <= 12'd0;
    end else begin
      r_hs_d1     <= hsync_n_i;
      r_vs_d1     <= vsync_n_i;
      r_de_d1     <= in_display_i;
      vga_hsync_n <= r_hs_d1;
      vga_vsync_n <= r_vs_d1;
      {vga_r, vga_g, vga_b} <= r_de_d1 ? w_pix : 12'd0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: drives compressed VGA lines, models the framebuffer,
// and scoreboards fetch addresses and the 2-cycle-delayed pixel/sync stream.
module tb_vga_pixel_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       hsync_n, vsync_n, in_display;
  logic [9:0] hcount, vcount;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync_n, vga_vsync_n, underrun;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_pattern;
`endif

  vga_pixel_fetch_if bus ();

  vga_pixel_fetch dut (
    .clk_75MHz    (clk),
    .reset        (reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern_i (test_pattern),
`endif
    .hsync_n_i    (hsync_n),
    .vsync_n_i    (vsync_n),
    .in_display_i (in_display),
    .hcount_i     (hcount),
    .vcount_i     (vcount),
    .fb           (bus.master),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hsync_n  (vga_hsync_n),
    .vga_vsync_n  (vga_vsync_n),
    .underrun     (underrun)
  );

  typedef struct packed {
    logic        chk;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t        pq[$];
  logic [31:0] aq[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_acc = 0, first_acc = 0, last_acc = 0;

  // Framebuffer contents: row r column c holds {r^1, c}, so row 1 column c holds c.
  function automatic logic [11:0] pix(int row, int col);
    logic [3:0] hi;
    logic [7:0] lo;
    hi = 4'(row ^ 1);
    lo = 8'(col);
    return {hi, lo};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic        acc;
    logic [15:0] a;
    logic [31:0] ea;
    exp_t        e;
    acc = bus.fb_addr_valid && bus.fb_addr_ready;
    a   = bus.fb_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (pq.size() >= 2) begin
      e = pq.pop_front();
      check("vga_hsync_n", 32'(vga_hsync_n), 32'(e.hs));
      check("vga_vsync_n", 32'(vga_vsync_n), 32'(e.vs));
      if (e.chk) check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
    end
    bus.fb_data_valid = acc;
    bus.fb_data       = pix(int'(a) / 256, int'(a) % 256);
    if (acc) begin
      n_acc++;
      if (n_acc == 1) first_acc = cyc;
      last_acc = cyc;
      ea = 32'hDEAD_BEEF;
      if (aq.size() > 0) ea = aq.pop_front();
      check("fb_addr", 32'(a), ea);
    end
  endtask

  task automatic drive_cycle(int h, int v, bit de, bit vs_n, int exp_row, bit rdy, bit tp);
    exp_t       e;
    logic [2:0] k;
    int         nxt;
    hsync_n    = !(h >= 1048 && h < 1184);
    vsync_n    = vs_n;
    in_display = de && (h < 1024);
    hcount     = 10'(h);
    vcount     = 10'(v);
    bus.fb_addr_ready = rdy;
`ifdef VGA_TEST_PATTERN_EN
    test_pattern = tp;
`endif
    e.hs = hsync_n;
    e.vs = vs_n;
    e.chk = 1'b1;
    e.rgb = 12'd0;
    if (in_display) begin
      if (tp) begin
        k = hcount[9:7];
        e.rgb = {3{k, k[0]}};
      end else begin
        e.chk = (exp_row >= 0);
        e.rgb = pix(exp_row, h >> 2);
      end
    end
    pq.push_back(e);
    if (h == 1048) begin
      nxt = (v == 805) ? 0 : v + 1;
      if (nxt < 768 && nxt % 4 == 0)
        for (int i = 0; i < 256; i++) aq.push_back(32'((nxt / 4) * 256 + i));
    end
    step();
  endtask

  task automatic run_line(int v, bit de, bit vs_n, int exp_row, int rdy_from, bit tp);
    for (int h = 0; h < 1328; h++) drive_cycle(h, v, de, vs_n, exp_row, h >= rdy_from, tp);
  endtask

  task automatic do_reset(int n);
    logic acc;
    exp_t e;
    acc = bus.fb_addr_valid && bus.fb_addr_ready;
    reset = 1'b1;
    hsync_n = 1'b0;
    vsync_n = 1'b0;
    in_display = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.fb_data_valid = (i == 0) ? acc : 1'b0;
      check("rst_addr_valid", 32'(bus.fb_addr_valid), 32'd0);
      check("rst_addr", 32'(bus.fb_addr), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      check("rst_hsync", 32'(vga_hsync_n), 32'd1);
      check("rst_vsync", 32'(vga_vsync_n), 32'd1);
    end
    reset = 1'b0;
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    in_display = 1'b0;
    pq.delete();
    aq.delete();
    n_acc = 0;
    e.chk = 1'b1; e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'd0;
    pq.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    hsync_n = 1'b1; vsync_n = 1'b1; in_display = 1'b0;
    hcount = '0; vcount = '0;
`ifdef VGA_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    bus.fb_addr_ready = 1'b1;
    bus.fb_data = '0;
    bus.fb_data_valid = 1'b0;

    do_reset(4);

    // Start a fetch, then reset in the middle of it.
    for (int h = 1040; h < 1076; h++) drive_cycle(h, 3, 1'b1, 1'b1, -1, 1'b1, 1'b0);
    check("valid_mid_fetch", 32'(bus.fb_addr_valid), 32'd1);
    do_reset(4);

    // Fetch row 1 with a zero-wait memory.
    n_acc = 0;
    run_line(3, 1'b1, 1'b1, -1, 0, 1'b0);
    check("row1_addr_q_empty", 32'(aq.size()), 32'd0);
    check("row1_beats", 32'(n_acc), 32'd256);
    check("row1_consecutive", 32'(last_acc - first_acc), 32'd255);
    check("row1_pending", 32'(dut.r_pending), 32'd1);

    // Lines 4..7 replicate row 1; line 7 fetches row 2 for line 8.
    for (int v = 4; v < 8; v++) run_line(v, 1'b1, 1'b1, 1, 0, 1'b0);
    run_line(8, 1'b1, 1'b1, 2, 0, 1'b0);
    check("row2_addr_q_empty", 32'(aq.size()), 32'd0);

    // Frame wrap: last line fetches row 0 for line 0.
    run_line(805, 1'b0, 1'b0, -1, 0, 1'b0);
    check("row0_addr_q_empty", 32'(aq.size()), 32'd0);
    run_line(0, 1'b1, 1'b1, 0, 0, 1'b0);

    // Underrun: memory refuses addresses through the next line start.
    run_line(3, 1'b1, 1'b1, 0, 100000, 1'b0);
    check("underrun_before", 32'(underrun), 32'd0);
    run_line(4, 1'b1, 1'b1, 0, 100, 1'b0);
    check("underrun_set", 32'(underrun), 32'd1);
    check("late_addr_q_empty", 32'(aq.size()), 32'd0);
    run_line(5, 1'b1, 1'b1, 1, 0, 1'b0);
    check("underrun_sticky", 32'(underrun), 32'd1);

`ifdef VGA_TEST_PATTERN_EN
    run_line(6, 1'b1, 1'b1, 1, 0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
